// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional feature macro used by this slice: FETCH_PERF_CNT_EN (see if_fetch_stage.sv).
package if_fetch_stage_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam logic [31:0] PC_INC   = 32'd4;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_e;

    // Instruction addresses are always word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// master = fetch stage (issues requests), slave = memory (returns words).
interface if_fetch_stage_if;
    import if_fetch_stage_pkg::*;

    logic               imem_req;
    logic [INSTR_W-1:0] imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/if_fetch_stage_fetch_pc_reg.sv
// PC and request-address registers for the fetch stage.
// pc is the architectural next-fetch target; req_addr is the address on the
// memory bus and may lag pc while a stale request is being drained.
module fetch_pc_reg
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adv_en,          // pc, req_addr <= req_addr + 4
    input  logic        req_from_pc_en,  // req_addr <= pc (end of drain)
    input  logic        redir_pc_en,     // pc <= aligned redirect target
    input  logic        redir_req_en,    // req_addr <= aligned redirect target
    input  logic [31:0] redirect_pc,
    output logic [31:0] req_addr,
    output logic [31:0] next_addr
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] target;

    assign target    = align_pc(redirect_pc);
    assign next_addr = req_addr_q + PC_INC;
    assign req_addr  = req_addr_q;

    // Next-value selection; redirect is applied last so it overrides advancing.
    always_comb begin
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        if (adv_en) begin
            pc_d       = next_addr;
            req_addr_d = next_addr;
        end
        if (req_from_pc_en) begin
            req_addr_d = pc_q;
        end
        if (redir_pc_en) begin
            pc_d = target;
        end
        if (redir_req_en) begin
            req_addr_d = target;
        end
    end

    // Address registers with synchronous reset to the boot PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency imem and
// presents a registered instruction/PC+4/valid triple to IF/ID.
// Optional macro FETCH_PERF_CNT_EN adds fetch_count/bubble_count outputs.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = if_fetch_stage_pkg::NOP_WORD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    if_fetch_stage_if.master       imem,
    output logic [31:0]            Instruction_out,
    output logic [31:0]            PC_4_out,
    output logic                   inst_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            fetch_count,
    output logic [31:0]            bubble_count
`endif
);
    import if_fetch_stage_pkg::*;

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [31:0]        pc4_q, pc4_d;
    logic               vld_q, vld_d;
    logic               req_q, req_d;
    logic [INSTR_W-1:0] buf_instr_q, buf_instr_d;
    logic [31:0]        buf_pc4_q, buf_pc4_d;

    logic        adv_en, req_from_pc_en, redir_pc_en, redir_req_en;
    logic        load_one, load_zero;
    logic [31:0] req_addr, next_addr;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk            (clk),
        .rst            (rst),
        .adv_en         (adv_en),
        .req_from_pc_en (req_from_pc_en),
        .redir_pc_en    (redir_pc_en),
        .redir_req_en   (redir_req_en),
        .redirect_pc    (redirect_pc),
        .req_addr       (req_addr),
        .next_addr      (next_addr)
    );

    assign imem.imem_req   = req_q;
    assign imem.imem_addr  = req_addr;
    assign Instruction_out = instr_q;
    assign PC_4_out        = pc4_q;
    assign inst_valid      = vld_q;

    // FSM next-state, output-register and PC-control decode.
    always_comb begin
        state_d        = state_q;
        instr_d        = instr_q;
        pc4_d          = pc4_q;
        vld_d          = vld_q;
        buf_instr_d    = buf_instr_q;
        buf_pc4_d      = buf_pc4_q;
        adv_en         = 1'b0;
        req_from_pc_en = 1'b0;
        redir_pc_en    = 1'b0;
        redir_req_en   = 1'b0;
        load_one       = 1'b0;
        load_zero      = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                if (redirect) begin
                    redir_pc_en  = 1'b1;
                    redir_req_en = 1'b1;
                end
            end
            S_FETCH: begin
                if (redirect) begin
                    // A same-cycle response is dropped; otherwise the old request
                    // must still complete on the bus before the new address goes out.
                    load_zero   = 1'b1;
                    redir_pc_en = 1'b1;
                    if (imem.imem_ready) begin
                        redir_req_en = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (imem.imem_ready) begin
                    adv_en = 1'b1;
                    if (stall) begin
                        // Memory completed but IF/ID is full: park the word.
                        buf_instr_d = imem.imem_rdata;
                        buf_pc4_d   = next_addr;
                        state_d     = S_HOLD;
                    end else begin
                        load_one = 1'b1;
                        instr_d  = imem.imem_rdata;
                        pc4_d    = next_addr;
                    end
                end else if (!stall) begin
                    load_zero = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    load_zero    = 1'b1;
                    redir_pc_en  = 1'b1;
                    redir_req_en = 1'b1;
                    state_d      = S_FETCH;
                end else if (!stall) begin
                    load_one = 1'b1;
                    instr_d  = buf_instr_q;
                    pc4_d    = buf_pc4_q;
                    state_d  = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (redirect) begin
                    load_zero   = 1'b1;
                    redir_pc_en = 1'b1;
                end else if (!stall) begin
                    load_zero = 1'b1;
                end
                if (imem.imem_ready) begin
                    // Stale response is discarded; restart at the latest target.
                    state_d = S_FETCH;
                    if (redirect) begin
                        redir_req_en = 1'b1;
                    end else begin
                        req_from_pc_en = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load_zero) begin
            vld_d   = 1'b0;
            instr_d = NOP_WORD;
        end
        if (load_one) begin
            vld_d = 1'b1;
        end
        req_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
    end

    // State and IF/ID output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            instr_q     <= NOP_WORD;
            pc4_q       <= '0;
            vld_q       <= 1'b0;
            req_q       <= 1'b0;
            buf_instr_q <= NOP_WORD;
            buf_pc4_q   <= '0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            pc4_q       <= pc4_d;
            vld_q       <= vld_d;
            req_q       <= req_d;
            buf_instr_q <= buf_instr_d;
            buf_pc4_q   <= buf_pc4_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Counter increments: real instructions loaded, and bubbles loaded while not stalled.
    always_comb begin
        fetch_cnt_d  = fetch_cnt_q + {31'd0, load_one};
        bubble_cnt_d = bubble_cnt_q + {31'd0, (load_zero && !stall)};
    end

    // Wrapping performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_count  = fetch_cnt_q;
    assign bubble_count = bubble_cnt_q;
`endif

endmodule
